// File: rtl/mdr_cmd_driver_pkg.sv
// Shared types for the MDR command driver: operand/result types, FSM states and response payload.
package mdr_cmd_driver_pkg;

    localparam int unsigned MDR_DW  = 16;
    localparam int unsigned MDR_DW2 = 2 * MDR_DW;
    localparam int unsigned TMO_W   = 8;

    typedef logic [MDR_DW-1:0]  data_in_t;
    typedef logic [MDR_DW2-1:0] data_t;
    typedef logic [MDR_DW-1:0]  reminder_t;

    typedef enum logic [1:0] {MULT = 2'd0, DIV = 2'd1, ROOT = 2'd2, NON = 2'd3} op_select_t;

    typedef enum logic [2:0] {
        IDLE, START, GAP_X, LOAD_X, GAP_Y, LOAD_Y, WAIT_DONE, RESP
    } drv_state_t;

    typedef enum logic [1:0] {RSP_OK, RSP_MDR_ERR, RSP_TIMEOUT, RSP_ILLEGAL} rsp_status_t;

    typedef struct packed {
        data_t       result;
        reminder_t   remainder;
        rsp_status_t status;
    } st_mdr_rsp;

endpackage

// File: rtl/mdr_cmd_driver_if.sv
// Command, MDR and response signals of the MDR command driver, seen from driver (master) or environment (slave).
interface mdr_cmd_driver_if #(
    parameter int unsigned DW = 16
) ();
    import mdr_cmd_driver_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    op_select_t        cmd_op;
    logic [DW-1:0]     cmd_x;
    logic [DW-1:0]     cmd_y;

    logic              mdr_start;
    op_select_t        mdr_op;
    logic              mdr_load;
    logic [DW-1:0]     mdr_data;
    logic              mdr_ready;
    logic              mdr_error;
    logic [2*DW-1:0]   mdr_result;
    logic [DW-1:0]     mdr_remainder;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*DW-1:0]   rsp_result;
    logic [DW-1:0]     rsp_remainder;
    rsp_status_t       rsp_status;

    modport master (
        input  cmd_valid, cmd_op, cmd_x, cmd_y,
        input  mdr_ready, mdr_error, mdr_result, mdr_remainder,
        input  rsp_ready,
        output cmd_ready, mdr_start, mdr_op, mdr_load, mdr_data,
        output rsp_valid, rsp_result, rsp_remainder, rsp_status
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_x, cmd_y,
        output mdr_ready, mdr_error, mdr_result, mdr_remainder,
        output rsp_ready,
        input  cmd_ready, mdr_start, mdr_op, mdr_load, mdr_data,
        input  rsp_valid, rsp_result, rsp_remainder, rsp_status
    );

endinterface

// File: rtl/mdr_drv_timer.sv
// Loadable saturating down-counter with a zero flag; used for both load gaps and the completion timeout.
module mdr_drv_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero_c
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/mdr_cmd_driver.sv
// Initiator for the MDR core: accepts one command, issues start plus two serial operand loads,
// waits for ready/error/timeout and returns the captured result on a valid/ready response port.
module mdr_cmd_driver
    import mdr_cmd_driver_pkg::*;
#(
    parameter int unsigned DW       = 16,
    parameter int unsigned LOAD_GAP = 1,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    mdr_cmd_driver_if.master bus
);

    localparam int unsigned      DW2     = 2 * DW;
    localparam bit               HAS_GAP = (LOAD_GAP != 0);
    localparam logic [TMO_W-1:0] GAP_LD  = TMO_W'((LOAD_GAP > 0) ? (LOAD_GAP - 1) : 0);
    localparam logic [TMO_W-1:0] TMO_LD  = TMO_W'(TIMEOUT - 1);

    drv_state_t       state;
    drv_state_t       state_d;
    op_select_t       op_q;
    logic [DW-1:0]    x_q;
    logic [DW-1:0]    y_q;
    st_mdr_rsp        rsp_q;
    logic             accept;

    logic             tmr_load;
    logic             tmr_dec;
    logic [TMO_W-1:0] tmr_val;
    logic             tmr_zero_c;

    logic             cmd_ready_q, cmd_ready_d;
    logic             mdr_start_q, mdr_start_d;
    logic             mdr_load_q,  mdr_load_d;
    logic [DW-1:0]    mdr_data_q,  mdr_data_d;
    op_select_t       mdr_op_q,    mdr_op_d;
    logic             rsp_valid_q, rsp_valid_d;

    assign accept = (state == IDLE) && bus.cmd_valid;

    mdr_drv_timer #(.W(TMO_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero_c   (tmr_zero_c)
    );

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            mdr_start_q <= 1'b0;
            mdr_load_q  <= 1'b0;
            mdr_data_q  <= '0;
            mdr_op_q    <= MULT;
            rsp_valid_q <= 1'b0;
        end else begin
            state       <= state_d;
            cmd_ready_q <= cmd_ready_d;
            mdr_start_q <= mdr_start_d;
            mdr_load_q  <= mdr_load_d;
            mdr_data_q  <= mdr_data_d;
            mdr_op_q    <= mdr_op_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Next state; the shared timer is (re)loaded on every entry into a counted state
    always_comb begin
        state_d  = state;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state)
            IDLE:      if (accept) state_d = (bus.cmd_op == NON) ? RESP : START;
            START:     state_d = HAS_GAP ? GAP_X : LOAD_X;
            GAP_X:     if (tmr_zero_c) state_d = LOAD_X;
            LOAD_X:    state_d = HAS_GAP ? GAP_Y : LOAD_Y;
            GAP_Y:     if (tmr_zero_c) state_d = LOAD_Y;
            LOAD_Y:    state_d = WAIT_DONE;
            WAIT_DONE: if (bus.mdr_error || bus.mdr_ready || tmr_zero_c) state_d = RESP;
            RESP:      if (bus.rsp_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (state_d != state) begin
            if ((state_d == GAP_X) || (state_d == GAP_Y)) begin
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end else if (state_d == WAIT_DONE) begin
                tmr_load = 1'b1;
                tmr_val  = TMO_LD;
            end
        end else begin
            tmr_dec = 1'b1;
        end
    end

    // Output values for the upcoming state, registered above
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        mdr_start_d = (state_d == START);
        mdr_load_d  = (state_d == LOAD_X) || (state_d == LOAD_Y);
        rsp_valid_d = (state_d == RESP);
        mdr_data_d  = '0;
        if (state_d == LOAD_X) mdr_data_d = x_q;
        if (state_d == LOAD_Y) mdr_data_d = y_q;
        mdr_op_d = MULT;
        if (state_d != IDLE) mdr_op_d = (state == IDLE) ? bus.cmd_op : op_q;
    end

    // Command latch and response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= MULT;
            x_q   <= '0;
            y_q   <= '0;
            rsp_q <= '0;
        end else begin
            if (accept) begin
                op_q <= bus.cmd_op;
                x_q  <= bus.cmd_x;
                y_q  <= (bus.cmd_op == ROOT) ? '0 : bus.cmd_y;
                if (bus.cmd_op == NON) begin
                    rsp_q.result    <= '0;
                    rsp_q.remainder <= '0;
                    rsp_q.status    <= RSP_ILLEGAL;
                end
            end
            if (state == WAIT_DONE) begin
                if (bus.mdr_error) begin
                    rsp_q.result    <= '0;
                    rsp_q.remainder <= '0;
                    rsp_q.status    <= RSP_MDR_ERR;
                end else if (bus.mdr_ready) begin
                    rsp_q.result    <= data_t'(bus.mdr_result);
                    rsp_q.remainder <= reminder_t'(bus.mdr_remainder);
                    rsp_q.status    <= RSP_OK;
                end else if (tmr_zero_c) begin
                    rsp_q.result    <= '0;
                    rsp_q.remainder <= '0;
                    rsp_q.status    <= RSP_TIMEOUT;
                end
            end
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.mdr_start     = mdr_start_q;
    assign bus.mdr_load      = mdr_load_q;
    assign bus.mdr_data      = mdr_data_q;
    assign bus.mdr_op        = mdr_op_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_result    = DW2'(rsp_q.result);
    assign bus.rsp_remainder = DW'(rsp_q.remainder);
    assign bus.rsp_status    = rsp_q.status;

endmodule

// File: tb/tb_mdr_cmd_driver.sv
// Bench for mdr_cmd_driver: directed and random transactions against a stand-in MDR core,
// with pulse timing and response contents predicted from the protocol rules.
module tb_mdr_cmd_driver;
    import mdr_cmd_driver_pkg::*;

    localparam int unsigned G = 1;
    localparam int unsigned T = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mdr_cmd_driver_if #(.DW(16)) bus ();

    mdr_cmd_driver #(.DW(16), .LOAD_GAP(G), .TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] isqrt(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 256; i++) if (i * i <= int'(v)) r = 16'(i);
        return r;
    endfunction

    function automatic void mdr_calc(input op_select_t op, input logic [15:0] a, input logic [15:0] b,
                                     output logic [31:0] res, output logic [15:0] rem);
        res = '0;
        rem = '0;
        case (op)
            MULT: res = 32'(a) * 32'(b);
            DIV:  if (b != 16'h0) begin res = 32'(a / b); rem = a % b; end
            ROOT: res = 32'(isqrt(a));
            default: ;
        endcase
    endfunction

    // Observed MDR-side pulses
    int          start_q[$];
    int          ld_cyc_q[$];
    logic [15:0] ld_dat_q[$];
    op_select_t  ld_op_q[$];
    int          data_leak = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mdr_start) start_q.push_back(cyc);
            if (bus.mdr_load) begin
                ld_cyc_q.push_back(cyc);
                ld_dat_q.push_back(bus.mdr_data);
                ld_op_q.push_back(bus.mdr_op);
            end else if (bus.mdr_data != 16'h0) begin
                data_leak++;
            end
        end
    end

    // Stand-in MDR core: mode 0 silent, 1 ready, 2 error, 3 both; answers mdl_delay cycles after the second load
    int          mdl_mode  = 0;
    int          mdl_delay = 1;
    int          nload     = 0;
    int          resp_at   = -1;
    logic [15:0] mx, my;
    op_select_t  mop;

    always @(negedge clk) begin
        if (rst) begin
            bus.mdr_ready     = 1'b0;
            bus.mdr_error     = 1'b0;
            bus.mdr_result    = '0;
            bus.mdr_remainder = '0;
            nload             = 0;
            resp_at           = -1;
        end else begin
            if (bus.rsp_valid) begin
                bus.mdr_ready = 1'b0;
                bus.mdr_error = 1'b0;
                resp_at       = -1;
            end
            if (bus.mdr_start) nload = 0;
            if (bus.mdr_load) begin
                if (nload == 0) mx = bus.mdr_data;
                else my = bus.mdr_data;
                mop = bus.mdr_op;
                nload++;
                if (nload == 2 && mdl_mode != 0) resp_at = cyc + mdl_delay;
            end
            if (resp_at >= 0 && cyc == resp_at) begin
                bus.mdr_error = (mdl_mode == 2) || (mdl_mode == 3);
                bus.mdr_ready = (mdl_mode == 1) || (mdl_mode == 3);
                mdr_calc(mop, mx, my, bus.mdr_result, bus.mdr_remainder);
            end
        end
    end

    task automatic clear_logs();
        start_q.delete();
        ld_cyc_q.delete();
        ld_dat_q.delete();
        ld_op_q.delete();
    endtask

    task automatic run_txn(input op_select_t op, input logic [15:0] x, input logic [15:0] y,
                           input int mode, input int d, input int hold);
        int          acc, w, exp_rsp, rsp_cyc, exp_n;
        logic [31:0] eres;
        logic [15:0] erem, yeff;
        rsp_status_t est;
        clear_logs();
        mdl_mode  = mode;
        mdl_delay = d;
        yeff      = (op == ROOT) ? 16'h0 : y;
        @(negedge clk);
        chk("idle_cmd_ready", bus.cmd_ready, 1);
        chk("idle_mdr_op", bus.mdr_op, MULT);
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_valid = 1'b1;
        acc           = cyc;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = 16'($urandom);
        bus.cmd_y     = 16'($urandom);
        bus.cmd_op    = op_select_t'(2'($urandom_range(0, 3)));

        // Reference: latency and contents from the protocol rules
        eres = '0;
        erem = '0;
        if (op == NON) begin
            est     = RSP_ILLEGAL;
            exp_rsp = acc + 1;
        end else begin
            w = acc + 4 + 2 * int'(G);
            if (mode == 0 || d > int'(T)) begin
                est     = RSP_TIMEOUT;
                exp_rsp = w + int'(T);
            end else if (mode >= 2) begin
                est     = RSP_MDR_ERR;
                exp_rsp = w + d;
            end else begin
                est     = RSP_OK;
                exp_rsp = w + d;
                mdr_calc(op, x, yeff, eres, erem);
            end
        end

        rsp_cyc = -1;
        for (int k = 0; k < 400 && rsp_cyc < 0; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) rsp_cyc = cyc;
        end
        chk("rsp_cycle", rsp_cyc, exp_rsp);
        chk("rsp_result", bus.rsp_result, eres);
        chk("rsp_remainder", bus.rsp_remainder, erem);
        chk("rsp_status", bus.rsp_status, est);

        exp_n = (op == NON) ? 0 : 1;
        chk("start_count", start_q.size(), exp_n);
        if (start_q.size() == 1 && exp_n == 1) chk("start_cycle", start_q[0], acc + 1);
        chk("load_count", ld_cyc_q.size(), 2 * exp_n);
        if (ld_cyc_q.size() == 2 && exp_n == 1) begin
            chk("load_x_cycle", ld_cyc_q[0], acc + 2 + int'(G));
            chk("load_y_cycle", ld_cyc_q[1], acc + 3 + 2 * int'(G));
            chk("load_x_data", ld_dat_q[0], x);
            chk("load_y_data", ld_dat_q[1], yeff);
            chk("load_op", ld_op_q[0], op);
        end

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", bus.rsp_valid, 1);
            chk("hold_cmd_ready", bus.cmd_ready, 0);
            chk("hold_result", bus.rsp_result, eres);
            chk("hold_status", bus.rsp_status, est);
        end

        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", bus.rsp_valid, 0);
        chk("post_cmd_ready", bus.cmd_ready, 1);
    endtask

    initial begin
        int          acc, k;
        op_select_t  op;
        logic [15:0] x, y;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = MULT;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.rsp_ready = 1'b0;
        rst           = 1'b1;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_mdr_start", bus.mdr_start, 0);
        chk("rst_mdr_load", bus.mdr_load, 0);
        chk("rst_mdr_data", bus.mdr_data, 0);
        chk("rst_rsp_status", bus.rsp_status, RSP_OK);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed protocol cases
        run_txn(MULT, 16'h00FF, 16'h0102, 1, 10, 0);
        chk("mult_const_result", bus.rsp_result, 32'h0001_00FE);
        run_txn(DIV, 16'd100, 16'd0, 2, 3, 0);
        run_txn(ROOT, 16'd144, 16'h1234, 1, 5, 0);
        chk("root_const_result", bus.rsp_result, 32'd12);
        run_txn(NON, 16'h5555, 16'hAAAA, 1, 2, 0);
        run_txn(MULT, 16'd3, 16'd4, 0, 1, 0);
        run_txn(DIV, 16'd50, 16'd7, 3, 4, 0);
        run_txn(DIV, 16'd1000, 16'd7, 1, 6, 20);
        run_txn(MULT, 16'd9, 16'd9, 1, int'(T), 1);
        run_txn(MULT, 16'd9, 16'd9, 1, int'(T) + 1, 0);

        // Reset during GAP_Y
        clear_logs();
        mdl_mode  = 1;
        mdl_delay = 5;
        @(negedge clk);
        bus.cmd_op    = MULT;
        bus.cmd_x     = 16'h1234;
        bus.cmd_y     = 16'h0005;
        bus.cmd_valid = 1'b1;
        acc           = cyc;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        k = 0;
        while (cyc < acc + 3 + int'(G) && k < 20) begin
            @(negedge clk);
            k++;
        end
        rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rst_mdr_start", bus.mdr_start, 0);
        chk("mid_rst_mdr_load", bus.mdr_load, 0);
        chk("mid_rst_mdr_data", bus.mdr_data, 0);
        chk("mid_rst_mdr_op", bus.mdr_op, MULT);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 0);
        chk("mid_rst_rsp_result", bus.rsp_result, 0);
        chk("mid_rst_rsp_status", bus.rsp_status, RSP_OK);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("mid_rst_loads", ld_cyc_q.size(), 1);
        chk("mid_rst_starts", start_q.size(), 1);
        chk("mid_rst_idle_valid", bus.rsp_valid, 0);

        // Random traffic
        for (int n = 0; n < 24; n++) begin
            op = op_select_t'(2'($urandom_range(0, 3)));
            x  = 16'($urandom);
            y  = 16'($urandom);
            if (op == DIV && y == 16'h0) y = 16'h1;
            run_txn(op, x, y, int'($urandom_range(0, 3)), int'($urandom_range(1, 80)),
                    int'($urandom_range(0, 3)));
        end

        chk("mdr_data_zero_outside_load", data_leak, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
